apf_cfg_regbank: RTL and testbench

Parametrised APF bridge configuration register bank. It replaces the fixed, reset-only cfg registers in the Pocket wrapper with a bridge-addressable bank of NUM_REGS 32-bit words. Writes land in a pending copy and commit to live outputs on the frame boundary (vsync rising edge), so caption settings never change mid-frame. Sits between the APF bridge and translation_overlay_top cfg_* inputs.

---
 rtl/apf_cfg_regbank_if.sv | 36 +++
 rtl/apf_cfg_regbank.sv | 204 ++++++++++++++++++++
 tb/tb_apf_cfg_regbank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apf_cfg_regbank_if.sv
// APF bridge register-access bus: address, one-cycle rd/wr strobes, data.
// Latency: none (plain wires); read data is registered inside the slave.
// Backpressure: none; the slave accepts every strobe in the cycle it is seen.
//
// Signals:
//   bridge_endian_little  1 = data as-is, 0 = byte-swapped on both data paths
//   bridge_addr           byte address, bits [1:0] ignored by the slave
//   bridge_rd / bridge_wr one-cycle request strobes
//   bridge_wr_data        write data
//   bridge_rd_data        read data, valid the cycle after bridge_rd
interface apf_cfg_regbank_if;
    logic        bridge_endian_little;
    logic [31:0] bridge_addr;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;

    modport master (
        output bridge_endian_little,
        output bridge_addr,
        output bridge_rd,
        output bridge_wr,
        output bridge_wr_data,
        input  bridge_rd_data
    );

    modport slave (
        input  bridge_endian_little,
        input  bridge_addr,
        input  bridge_rd,
        input  bridge_wr,
        input  bridge_wr_data,
        output bridge_rd_data
    );
endinterface

// File: rtl/apf_cfg_regbank.sv
// Bridge-addressable caption config bank; writes land in a pending copy that commits to live on vsync rise.
// Latency: read data 1 cycle after bridge_rd; wr_pulse/commit_pulse 1 cycle after the causing edge.
// Backpressure: none; every bridge strobe is serviced in the cycle it arrives.
//
// Ports: clk, rst_n (async, active-low); bridge (slave modport of apf_cfg_regbank_if);
//   vid_vs (vsync, same domain); cfg_* live config outputs; cfg_scratch = words 5..NUM_REGS-1,
//   word 5 in the LSBs; wr_pulse[i] on accepted write to word i; commit_pulse on pending->live copy.
// Build option: define APF_CFG_SHADOW_EN for pending/live shadowing with frame-boundary commit;
//   without it a single register set drives cfg_* directly.
module apf_cfg_regbank #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] ID_VALUE  = 32'h5452_0001
) (
    input  logic                       clk,
    input  logic                       rst_n,
    apf_cfg_regbank_if.slave           bridge,
    input  logic                       vid_vs,
    output logic                       cfg_enable,
    output logic                       cfg_mode,
    output logic [14:0]                cfg_caption_color,
    output logic [7:0]                 cfg_caption_y,
    output logic [32*(NUM_REGS-5)-1:0] cfg_scratch,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic                       commit_pulse
);
    localparam int          AW        = $clog2(NUM_REGS);
    localparam logic [14:0] COLOR_RST = 15'h7FFF;
    localparam logic [7:0]  Y_RST     = 8'd128;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Pending (bridge-visible) copy
    logic [1:0]  ctrl_q, ctrl_d;
    logic [14:0] color_q, color_d;
    logic [7:0]  y_q, y_d;
    logic [31:0] scr_q [5:NUM_REGS-1];
    logic [31:0] scr_d [5:NUM_REGS-1];

    logic        dirty_q, dirty_d;
    logic        err_q, err_d;
    logic        vs_q;
    logic [15:0] frame_cnt_q;
    logic [31:0] rd_data_q;
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic        commit_pulse_q;

    logic                base_hit;
    logic [AW-1:0]       idx;
    logic [NUM_REGS-1:0] hit;
    logic                in_range, wr_ok, wr_rw, acc_bad, vs_rise, commit_evt;
    logic [31:0]         wdat, rd_word;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^bridge.bridge_addr[1:0];

    // Base is aligned to the power-of-two block, so the upper bits select the bank
    // and the low AW word bits index within it.
    assign base_hit = (bridge.bridge_addr[31:2+AW] == BASE_ADDR[31:2+AW]);
    assign idx      = bridge.bridge_addr[2+AW-1:2];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = base_hit && (idx == AW'(i));
        end
    end

    assign in_range = |hit;
    assign wr_ok    = bridge.bridge_wr && in_range;
    assign wr_rw    = wr_ok && !hit[3] && !hit[4];
    assign acc_bad  = (bridge.bridge_rd || bridge.bridge_wr) && !in_range;
    assign wdat     = bridge.bridge_endian_little ? bridge.bridge_wr_data : bswap32(bridge.bridge_wr_data);
    assign vs_rise  = vid_vs && !vs_q;

    // Read mux sees pre-write state, so a same-cycle write is not reflected.
    always_comb begin
        rd_word = '0;
        if (hit[0]) rd_word = {30'b0, ctrl_q};
        if (hit[1]) rd_word = {17'b0, color_q};
        if (hit[2]) rd_word = {24'b0, y_q};
        if (hit[3]) rd_word = {frame_cnt_q, 14'b0, err_q, dirty_q};
        if (hit[4]) rd_word = ID_VALUE;
        for (int i = 5; i < NUM_REGS; i++) begin
            if (hit[i]) rd_word = scr_q[i];
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        color_d = color_q;
        y_d     = y_q;
        scr_d   = scr_q;
        if (wr_ok) begin
            if (hit[0]) ctrl_d  = wdat[1:0];
            if (hit[1]) color_d = wdat[14:0];
            if (hit[2]) y_d     = wdat[7:0];
            for (int i = 5; i < NUM_REGS; i++) begin
                if (hit[i]) scr_d[i] = wdat;
            end
        end
    end

    // A bad access in the same cycle as an err-clear wins: the error is newer.
    always_comb begin
        err_d = err_q;
        if (wr_ok && hit[3] && wdat[1]) err_d = 1'b0;
        if (acc_bad)                    err_d = 1'b1;
    end

`ifdef APF_CFG_SHADOW_EN
    logic        commit_now;
    logic [1:0]  ctrl_l_q;
    logic [14:0] color_l_q;
    logic [7:0]  y_l_q;
    logic [31:0] scr_l_q [5:NUM_REGS-1];

    assign commit_now = wr_ok && hit[0] && wdat[31];
    assign commit_evt = commit_now || vs_rise;

    // commit_now copies the merged pending state; a plain vs rise copies the
    // pre-write state so a coincident write waits for the next frame.
    always_comb begin
        if (commit_now)   dirty_d = 1'b0;
        else if (vs_rise) dirty_d = wr_rw;
        else              dirty_d = dirty_q || wr_rw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_l_q  <= '0;
            color_l_q <= COLOR_RST;
            y_l_q     <= Y_RST;
            for (int i = 5; i < NUM_REGS; i++) scr_l_q[i] <= '0;
        end else if (commit_now) begin
            ctrl_l_q  <= ctrl_d;
            color_l_q <= color_d;
            y_l_q     <= y_d;
            scr_l_q   <= scr_d;
        end else if (vs_rise) begin
            ctrl_l_q  <= ctrl_q;
            color_l_q <= color_q;
            y_l_q     <= y_q;
            scr_l_q   <= scr_q;
        end
    end

    assign cfg_enable        = ctrl_l_q[0];
    assign cfg_mode          = ctrl_l_q[1];
    assign cfg_caption_color = color_l_q;
    assign cfg_caption_y     = y_l_q;
    always_comb begin
        cfg_scratch = '0;
        for (int i = 5; i < NUM_REGS; i++) cfg_scratch[32*(i-5) +: 32] = scr_l_q[i];
    end
`else
    assign dirty_d    = 1'b0;
    assign commit_evt = wr_rw;

    assign cfg_enable        = ctrl_q[0];
    assign cfg_mode          = ctrl_q[1];
    assign cfg_caption_color = color_q;
    assign cfg_caption_y     = y_q;
    always_comb begin
        cfg_scratch = '0;
        for (int i = 5; i < NUM_REGS; i++) cfg_scratch[32*(i-5) +: 32] = scr_q[i];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q         <= '0;
            color_q        <= COLOR_RST;
            y_q            <= Y_RST;
            for (int i = 5; i < NUM_REGS; i++) scr_q[i] <= '0;
            dirty_q        <= 1'b0;
            err_q          <= 1'b0;
            vs_q           <= 1'b0;
            frame_cnt_q    <= '0;
            rd_data_q      <= '0;
            wr_pulse_q     <= '0;
            commit_pulse_q <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            color_q        <= color_d;
            y_q            <= y_d;
            scr_q          <= scr_d;
            dirty_q        <= dirty_d;
            err_q          <= err_d;
            vs_q           <= vid_vs;
            if (vs_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (bridge.bridge_rd) begin
                rd_data_q <= bridge.bridge_endian_little ? rd_word : bswap32(rd_word);
            end
            wr_pulse_q     <= wr_ok ? hit : '0;
            commit_pulse_q <= commit_evt;
        end
    end

    assign bridge.bridge_rd_data = rd_data_q;
    assign wr_pulse              = wr_pulse_q;
    assign commit_pulse          = commit_pulse_q;
endmodule

// File: tb/tb_apf_cfg_regbank.sv
// Testbench for apf_cfg_regbank: directed scenarios plus randomized traffic vs a word-level model.
// Latency: checks sample outputs 1 time unit after each rising clock edge.
// Backpressure: none; one bridge operation per cycle.
module tb_apf_cfg_regbank;
    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] ID   = 32'h5452_0001;
`ifdef APF_CFG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic vid_vs;
    logic cfg_enable, cfg_mode, commit_pulse;
    logic [14:0] cfg_caption_color;
    logic [7:0]  cfg_caption_y;
    logic [32*(NR-5)-1:0] cfg_scratch;
    logic [NR-1:0] wr_pulse;

    apf_cfg_regbank_if bus ();

    apf_cfg_regbank #(.NUM_REGS(NR), .BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
        .clk(clk), .rst_n(rst_n), .bridge(bus), .vid_vs(vid_vs),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_caption_color(cfg_caption_color), .cfg_caption_y(cfg_caption_y),
        .cfg_scratch(cfg_scratch), .wr_pulse(wr_pulse), .commit_pulse(commit_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Word-level model: each entry holds the value a read of that word returns.
    logic [31:0] m_pend [NR];
    logic [31:0] m_live [NR];
    bit          m_err, m_dirty, m_vs, m_commit;
    logic [15:0] m_fcnt;
    logic [31:0] m_rd;
    logic [NR-1:0] m_wrp;

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] wmask(input int i);
        case (i)
            0:       return 32'h0000_0003;
            1:       return 32'h0000_7FFF;
            2:       return 32'h0000_00FF;
            3, 4:    return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [24:0] exp_cfg();
        return {m_live[0][1:0], m_live[1][14:0], m_live[2][7:0]};
    endfunction

    function automatic logic [32*(NR-5)-1:0] exp_scr();
        logic [32*(NR-5)-1:0] v;
        v = '0;
        for (int i = 5; i < NR; i++) v[32*(i-5) +: 32] = m_live[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_pend[i] = 32'h0;
        m_pend[1] = 32'h0000_7FFF;
        m_pend[2] = 32'h0000_0080;
        m_live = m_pend;
        m_err = 0; m_dirty = 0; m_vs = 0; m_commit = 0;
        m_fcnt = 0; m_rd = 0; m_wrp = '0;
    endtask

    // Drives one cycle of bridge/vsync activity and advances the model across that edge.
    task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit vs, input bit le);
        bit inr, rw, cnow, vsr;
        int idx;
        logic [31:0] rv, wd;
        logic [31:0] old [NR];
        @(negedge clk);
        bus.bridge_rd = rd; bus.bridge_wr = wr; bus.bridge_addr = addr;
        bus.bridge_wr_data = data; bus.bridge_endian_little = le; vid_vs = vs;

        inr = (addr >= BASE) && ({32'h0, addr} < {32'h0, BASE} + 64'(4 * NR));
        idx = inr ? int'((addr - BASE) >> 2) : 0;
        rv  = (idx == 3) ? {m_fcnt, 14'b0, m_err, m_dirty} : (idx == 4) ? ID : m_pend[idx];
        if (rd) m_rd = inr ? (le ? rv : swap(rv)) : 32'h0;
        wd   = le ? data : swap(data);
        rw   = wr && inr && idx != 3 && idx != 4;
        cnow = rw && idx == 0 && wd[31];
        vsr  = vs && !m_vs;
        old  = m_pend;
        if (rw) m_pend[idx] = wd & wmask(idx);
        if (wr && inr && idx == 3 && wd[1]) m_err = 0;
        if ((rd || wr) && !inr) m_err = 1;
        if (SHADOW) begin
            if (cnow) begin m_live = m_pend; m_dirty = 0; end
            else if (vsr) begin m_live = old; m_dirty = rw; end
            else m_dirty = m_dirty || rw;
            m_commit = cnow || vsr;
        end else begin
            m_live = m_pend; m_dirty = 0; m_commit = rw;
        end
        m_wrp = (wr && inr) ? NR'(1) << idx : '0;
        if (vsr) m_fcnt = m_fcnt + 16'd1;
        m_vs = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.bridge_rd = 0; bus.bridge_wr = 0; bus.bridge_addr = 0;
        bus.bridge_wr_data = 0; bus.bridge_endian_little = 1; vid_vs = 0;
        rst_n = 0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [5];
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0000_7FFF; exp_rd[2] = 32'h0000_0080;
        exp_rd[3] = 32'h0; exp_rd[4] = 32'h5452_0001;
        do_reset();
        n_checks++; if (bus.bridge_rd_data !== 32'h0) $display("FAIL reset_rd_data got=%h exp=0", bus.bridge_rd_data); else n_pass++;
        n_checks++; if (cfg_caption_y !== 8'd128) $display("FAIL reset_y got=%0d exp=128", cfg_caption_y); else n_pass++;
        n_checks++; if (cfg_caption_color !== 15'h7FFF) $display("FAIL reset_color got=%h exp=7fff", cfg_caption_color); else n_pass++;
        n_checks++; if ({cfg_mode, cfg_enable, wr_pulse, commit_pulse} !== '0) $display("FAIL reset_ctrl_pulses got=%b exp=0", {cfg_mode, cfg_enable, wr_pulse, commit_pulse}); else n_pass++;
        n_checks++; if (cfg_scratch !== '0) $display("FAIL reset_scratch got=%h exp=0", cfg_scratch); else n_pass++;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, BASE + 32'(4 * i), 0, 0, 1);
            n_checks++; if (bus.bridge_rd_data !== exp_rd[i]) $display("FAIL reset_read_w%0d got=%h exp=%h", i, bus.bridge_rd_data, exp_rd[i]); else n_pass++;
        end
    endtask

    task automatic test_deferred_commit();
        step(0, 1, BASE + 8, 32'h40, 0, 1);
        n_checks++; if (cfg_caption_y !== m_live[2][7:0]) $display("FAIL defer_y_before got=%h exp=%h", cfg_caption_y, m_live[2][7:0]); else n_pass++;
        step(1, 0, BASE + 12, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== m_rd) $display("FAIL defer_status_dirty got=%h exp=%h", bus.bridge_rd_data, m_rd); else n_pass++;
        step(0, 0, 0, 0, 1, 1);
        n_checks++; if (cfg_caption_y !== 8'h40) $display("FAIL defer_y_after got=%h exp=40", cfg_caption_y); else n_pass++;
        n_checks++; if (commit_pulse !== m_commit) $display("FAIL defer_commit_pulse got=%b exp=%b", commit_pulse, m_commit); else n_pass++;
        step(1, 0, BASE + 12, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== 32'h0001_0000) $display("FAIL defer_status_after got=%h exp=00010000", bus.bridge_rd_data); else n_pass++;
    endtask

    task automatic test_commit_now();
        step(0, 1, BASE, 32'h8000_0003, 0, 1);
        n_checks++; if ({cfg_mode, cfg_enable} !== 2'b11) $display("FAIL cnow_ctrl got=%b exp=11", {cfg_mode, cfg_enable}); else n_pass++;
        n_checks++; if (commit_pulse !== 1'b1) $display("FAIL cnow_commit_pulse got=%b exp=1", commit_pulse); else n_pass++;
        step(1, 0, BASE, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== 32'h3) $display("FAIL cnow_readback got=%h exp=3", bus.bridge_rd_data); else n_pass++;
    endtask

    task automatic test_vs_coincident();
        step(0, 1, BASE + 4, 32'h1F, 1, 1);
        n_checks++; if (cfg_caption_color !== m_live[1][14:0]) $display("FAIL coinc_color_now got=%h exp=%h", cfg_caption_color, m_live[1][14:0]); else n_pass++;
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (cfg_caption_color !== m_live[1][14:0]) $display("FAIL coinc_color_hold got=%h exp=%h", cfg_caption_color, m_live[1][14:0]); else n_pass++;
        step(0, 0, 0, 0, 1, 1);
        n_checks++; if (cfg_caption_color !== 15'h001F) $display("FAIL coinc_color_next got=%h exp=001f", cfg_caption_color); else n_pass++;
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_err();
        step(1, 0, 32'h0000_2000, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== 32'h0) $display("FAIL err_oor_read got=%h exp=0", bus.bridge_rd_data); else n_pass++;
        step(1, 0, BASE + 12, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data[1] !== 1'b1) $display("FAIL err_set got=%b exp=1", bus.bridge_rd_data[1]); else n_pass++;
        step(0, 1, BASE + 12, 32'h2, 0, 1);
        n_checks++; if (wr_pulse !== 8'h08) $display("FAIL err_wr_pulse3 got=%h exp=08", wr_pulse); else n_pass++;
        step(1, 0, BASE + 12, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data[1] !== 1'b0) $display("FAIL err_clear got=%b exp=0", bus.bridge_rd_data[1]); else n_pass++;
        step(0, 1, BASE + 32, 32'hDEAD, 0, 1);
        n_checks++; if (wr_pulse !== 8'h00) $display("FAIL err_oor_no_pulse got=%h exp=00", wr_pulse); else n_pass++;
    endtask

    task automatic test_endian();
        step(0, 1, BASE + 20, 32'h1122_3344, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        n_checks++; if (cfg_scratch[31:0] !== 32'h4433_2211) $display("FAIL endian_live got=%h exp=44332211", cfg_scratch[31:0]); else n_pass++;
        step(1, 0, BASE + 20, 0, 0, 0);
        n_checks++; if (bus.bridge_rd_data !== 32'h1122_3344) $display("FAIL endian_readback got=%h exp=11223344", bus.bridge_rd_data); else n_pass++;
        step(1, 0, BASE + 20, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== 32'h4433_2211) $display("FAIL endian_le_read got=%h exp=44332211", bus.bridge_rd_data); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        step(0, 1, BASE + 8, 32'h55, 0, 1);
        do_reset();
        @(negedge clk); rst_n = 1;
        step(1, 0, BASE + 8, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== 32'h80) $display("FAIL midrst_pending got=%h exp=80", bus.bridge_rd_data); else n_pass++;
        n_checks++; if (cfg_caption_y !== 8'd128) $display("FAIL midrst_y got=%0d exp=128", cfg_caption_y); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] addr, data;
        bit rd, wr, vs, le;
        int r;
        vs = 0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       addr = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(0, 3));
            else if (r == 8) addr = BASE + 32'(4 * NR);
            else             addr = $urandom;
            data = $urandom;
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            le = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) vs = ~vs;
            step(rd, wr, addr, data, vs, le);
            n_checks++; if (bus.bridge_rd_data !== m_rd) $display("FAIL rand_rd_data n=%0d got=%h exp=%h", n, bus.bridge_rd_data, m_rd); else n_pass++;
            n_checks++; if ({cfg_mode, cfg_enable, cfg_caption_color, cfg_caption_y} !== exp_cfg()) $display("FAIL rand_cfg n=%0d got=%h exp=%h", n, {cfg_mode, cfg_enable, cfg_caption_color, cfg_caption_y}, exp_cfg()); else n_pass++;
            n_checks++; if (cfg_scratch !== exp_scr()) $display("FAIL rand_scratch n=%0d got=%h exp=%h", n, cfg_scratch, exp_scr()); else n_pass++;
            n_checks++; if ({wr_pulse, commit_pulse} !== {m_wrp, m_commit}) $display("FAIL rand_pulses n=%0d got=%b exp=%b", n, {wr_pulse, commit_pulse}, {m_wrp, m_commit}); else n_pass++;
        end
        step(1, 0, BASE + 12, 0, 0, 1);
        n_checks++; if (bus.bridge_rd_data !== m_rd) $display("FAIL rand_final_status got=%h exp=%h", bus.bridge_rd_data, m_rd); else n_pass++;
    endtask

    initial begin
        rst_n = 0;
        vid_vs = 0;
        bus.bridge_rd = 0; bus.bridge_wr = 0; bus.bridge_addr = 0;
        bus.bridge_wr_data = 0; bus.bridge_endian_little = 1;
        test_reset();
        test_deferred_commit();
        test_commit_now();
        test_vs_coincident();
        test_err();
        test_endian();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
